// File: rtl/oflow_iou_pkg.sv
// rtl/oflow_iou_pkg.sv - shared widths, box struct and helpers for the IoU calculator
//
// Purpose: constants used by every file of the IoU slice, the packed box
// layout {x_tl, y_tl, x_br, y_br} and small arithmetic helpers for stage 1.
// Ports: none (package).
package oflow_iou_pkg;

  localparam int COORD_W  = 11;
  localparam int BOX_W    = 44;
  localparam int AREA_W   = 22;
  localparam int IOU_W    = 22;
  localparam int IOU_FRAC = 21;
  localparam int UNION_W  = 24;
  localparam int NUM_W    = AREA_W + IOU_FRAC;

  localparam logic [IOU_W-1:0] IOU_ONE = 22'h200000;

  typedef struct packed {
    logic [COORD_W-1:0] x_tl;
    logic [COORD_W-1:0] y_tl;
    logic [COORD_W-1:0] x_br;
    logic [COORD_W-1:0] y_br;
  } bbox_pos_t;

  function automatic bbox_pos_t unpack_bbox(input logic [BOX_W-1:0] v);
    return bbox_pos_t'(v);
  endfunction

  // Length of the overlap of [tl_a, br_a) and [tl_b, br_b); br is exclusive,
  // so touching intervals give zero. The difference is taken signed one bit
  // wider than a coordinate and clamped at zero.
  function automatic logic [COORD_W-1:0] overlap_len(
    input logic [COORD_W-1:0] tl_a,
    input logic [COORD_W-1:0] br_a,
    input logic [COORD_W-1:0] tl_b,
    input logic [COORD_W-1:0] br_b
  );
    logic [COORD_W-1:0] hi;
    logic [COORD_W-1:0] lo;
    logic signed [COORD_W:0] diff;
    hi   = (br_a < br_b) ? br_a : br_b;
    lo   = (tl_a > tl_b) ? tl_a : tl_b;
    diff = $signed({1'b0, hi}) - $signed({1'b0, lo});
    return (diff > 0) ? diff[COORD_W-1:0] : '0;
  endfunction

  function automatic logic [AREA_W-1:0] area_of(
    input logic [COORD_W-1:0] w,
    input logic [COORD_W-1:0] h
  );
    logic [AREA_W-1:0] ww;
    logic [AREA_W-1:0] hh;
    ww = AREA_W'(w);
    hh = AREA_W'(h);
    return ww * hh;
  endfunction

endpackage

// File: rtl/oflow_iou_div.sv
// rtl/oflow_iou_div.sv - combinational unsigned restoring divider for the IoU quotient
//
// Purpose: quotient = floor(numerator / divisor), truncated to its low IOU_W
// bits. The caller masks the divisor == 0 case.
// Ports:
//   numerator  in  NUM_W   dividend (intersection << IOU_FRAC)
//   divisor    in  UNION_W unsigned divisor (positive union)
//   quotient   out IOU_W   low IOU_W bits of the quotient
module oflow_iou_div
  import oflow_iou_pkg::*;
(
  input  logic [NUM_W-1:0]   numerator,
  input  logic [UNION_W-1:0] divisor,
  output logic [IOU_W-1:0]   quotient
);

  // The partial remainder stays below the divisor, so one extra bit is enough
  // to hold it after the shift-in.
  logic [UNION_W:0] rem;
  logic             q_bit;

  always_comb begin
    rem      = '0;
    q_bit    = 1'b0;
    quotient = '0;
    for (int i = NUM_W - 1; i >= 0; i--) begin
      rem   = {rem[UNION_W-1:0], numerator[i]};
      q_bit = (rem >= {1'b0, divisor});
      if (q_bit) begin
        rem = rem - {1'b0, divisor};
      end
      // Quotient bits above IOU_W still drive the remainder but are dropped.
      if (i < IOU_W) begin
        quotient = {quotient[IOU_W-2:0], q_bit};
      end
    end
  end

endmodule

// File: rtl/oflow_iou_calc.sv
// rtl/oflow_iou_calc.sv - 3-stage pipelined IoU of a frame-k box and a history box
//
// Purpose: iou = floor((inter << 21) / union) in unsigned Q1.21, one box pair
// per cycle, 3-cycle latency, no handshake.
// Build option: OFLOW_IOU_CLAMP_EN saturates the result to 1.0 when the
// intersection is non-zero and the union is non-positive or not larger than it.
// Ports:
//   clk                          in  1   rising-edge clock
//   reset_N                      in  1   asynchronous reset, active high
//   bbox_position_frame_k        in  44  {x_tl, y_tl, x_br, y_br}
//   bbox_position_frame_history  in  44  same packing
//   bbox_w_frame_k / bbox_h_frame_k             in 11 frame-k size
//   bbox_w_frame_history / bbox_h_frame_history in 11 history size
//   iou                          out 22  Q1.21 score
module oflow_iou_calc
  import oflow_iou_pkg::*;
(
  input  logic               clk,
  input  logic               reset_N,
  input  logic [BOX_W-1:0]   bbox_position_frame_k,
  input  logic [BOX_W-1:0]   bbox_position_frame_history,
  input  logic [COORD_W-1:0] bbox_w_frame_k,
  input  logic [COORD_W-1:0] bbox_h_frame_k,
  input  logic [COORD_W-1:0] bbox_w_frame_history,
  input  logic [COORD_W-1:0] bbox_h_frame_history,
  output logic [IOU_W-1:0]   iou
);

  bbox_pos_t box_k;
  bbox_pos_t box_h;

  assign box_k = unpack_bbox(bbox_position_frame_k);
  assign box_h = unpack_bbox(bbox_position_frame_history);

  // Stage 1: overlap extents and both areas (areas come from w/h, not coordinates).
  logic [COORD_W-1:0] s1_ow;
  logic [COORD_W-1:0] s1_oh;
  logic [AREA_W-1:0]  s1_area_k;
  logic [AREA_W-1:0]  s1_area_h;

  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      s1_ow     <= '0;
      s1_oh     <= '0;
      s1_area_k <= '0;
      s1_area_h <= '0;
    end else begin
      s1_ow     <= overlap_len(box_k.x_tl, box_k.x_br, box_h.x_tl, box_h.x_br);
      s1_oh     <= overlap_len(box_k.y_tl, box_k.y_br, box_h.y_tl, box_h.y_br);
      s1_area_k <= area_of(bbox_w_frame_k, bbox_h_frame_k);
      s1_area_h <= area_of(bbox_w_frame_history, bbox_h_frame_history);
    end
  end

  // Stage 2: intersection and union. Union is signed because inconsistent w/h
  // inputs can make it zero or negative.
  logic [AREA_W-1:0]         inter_d;
  logic signed [UNION_W-1:0] union_d;
  logic [AREA_W-1:0]         s2_inter;
  logic signed [UNION_W-1:0] s2_union;

  assign inter_d = area_of(s1_ow, s1_oh);
  assign union_d = $signed({2'b00, s1_area_k}) + $signed({2'b00, s1_area_h})
                 - $signed({2'b00, inter_d});

  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      s2_inter <= '0;
      s2_union <= '0;
    end else begin
      s2_inter <= inter_d;
      s2_union <= union_d;
    end
  end

  // Stage 3: divide and register onto iou.
  logic [NUM_W-1:0]   numerator;
  logic [UNION_W-1:0] divisor;
  logic [IOU_W-1:0]   quotient;
  logic               union_nonpos;
  logic [IOU_W-1:0]   iou_d;

  assign numerator    = {s2_inter, {IOU_FRAC{1'b0}}};
  assign divisor      = s2_union;
  assign union_nonpos = s2_union[UNION_W-1] || (s2_union == '0);

  oflow_iou_div u_div (
    .numerator (numerator),
    .divisor   (divisor),
    .quotient  (quotient)
  );

  always_comb begin
    iou_d = '0;
`ifdef OFLOW_IOU_CLAMP_EN
    if ((s2_inter != '0) && (union_nonpos || ({2'b00, s2_inter} >= divisor))) begin
      iou_d = IOU_ONE;
    end else if (!union_nonpos) begin
      iou_d = quotient;
    end
`else
    if (!union_nonpos) begin
      iou_d = quotient;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      iou <= '0;
    end else begin
      iou <= iou_d;
    end
  end

endmodule

// File: tb/tb_oflow_iou_calc.sv
// tb/tb_oflow_iou_calc.sv - scoreboard bench for oflow_iou_calc
module tb_oflow_iou_calc;

  logic        clk = 1'b0;
  logic        reset_N;
  logic [43:0] pos_k;
  logic [43:0] pos_h;
  logic [10:0] w_k;
  logic [10:0] h_k;
  logic [10:0] w_h;
  logic [10:0] h_h;
  logic [21:0] iou;

  always #5 clk = ~clk;

  oflow_iou_calc dut (
    .clk                         (clk),
    .reset_N                     (reset_N),
    .bbox_position_frame_k       (pos_k),
    .bbox_position_frame_history (pos_h),
    .bbox_w_frame_k              (w_k),
    .bbox_h_frame_k              (h_k),
    .bbox_w_frame_history        (w_h),
    .bbox_h_frame_history        (h_h),
    .iou                         (iou)
  );

  typedef struct {
    int x0;
    int y0;
    int x1;
    int y1;
    int w;
    int h;
  } box_t;

  typedef struct {
    logic [21:0] exp;
    int          due;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   tag_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: IoU from the box geometry with plain integer arithmetic.
  function automatic logic [21:0] ref_iou(input box_t k, input box_t h);
    longint ow;
    longint oh;
    longint inter;
    longint un;
    longint q;
    ow = ((k.x1 < h.x1) ? k.x1 : h.x1) - ((k.x0 > h.x0) ? k.x0 : h.x0);
    oh = ((k.y1 < h.y1) ? k.y1 : h.y1) - ((k.y0 > h.y0) ? k.y0 : h.y0);
    if (ow < 0) ow = 0;
    if (oh < 0) oh = 0;
    inter = ow * oh;
    un    = longint'(k.w) * k.h + longint'(h.w) * h.h - inter;
`ifdef OFLOW_IOU_CLAMP_EN
    if (inter > 0 && (un <= 0 || inter >= un)) return 22'h200000;
`endif
    if (un <= 0) return 22'd0;
    q = (inter << 21) / un;
    return q[21:0];
  endfunction

  function automatic logic [43:0] pack_box(input box_t b);
    return {b.x0[10:0], b.y0[10:0], b.x1[10:0], b.y1[10:0]};
  endfunction

  function automatic box_t mk(input int x0, input int y0, input int x1, input int y1,
                              input int w, input int h);
    box_t b;
    b.x0 = x0; b.y0 = y0; b.x1 = x1; b.y1 = y1; b.w = w; b.h = h;
    return b;
  endfunction

  function automatic box_t rand_box(input int lim, input bit bad_wh);
    box_t b;
    b.x0 = $urandom_range(lim - 1, 0);
    b.y0 = $urandom_range(lim - 1, 0);
    b.x1 = $urandom_range(lim, b.x0);
    b.y1 = $urandom_range(lim, b.y0);
    b.w  = bad_wh ? int'($urandom_range(2047, 0)) : b.x1 - b.x0;
    b.h  = bad_wh ? int'($urandom_range(2047, 0)) : b.y1 - b.y0;
    return b;
  endfunction

  // Called just after a rising edge; the pair is sampled on the next edge and
  // its result is visible after the third edge from now.
  task automatic drive(input box_t k, input box_t h, input logic [21:0] exp);
    pos_k = pack_box(k);
    pos_h = pack_box(h);
    w_k   = k.w[10:0];
    h_k   = k.h[10:0];
    w_h   = h.w[10:0];
    h_h   = h.h[10:0];
    sb.push_back('{exp: exp, due: cyc + 3, tag: tag_id});
    tag_id++;
    @(posedge clk); #1;
  endtask

  // Release just after an edge: the next two results come from the cleared
  // pipeline and must be zero.
  task automatic release_reset();
    reset_N = 1'b0;
    sb.push_back('{exp: 22'd0, due: cyc + 1, tag: -1});
    sb.push_back('{exp: 22'd0, due: cyc + 2, tag: -1});
  endtask

  task automatic mid_reset();
    #2;
    reset_N = 1'b1;
    #1;
    n_cmp++;
    if (iou !== 22'd0) begin
      n_bad++;
      $display("FAIL async_reset: iou=%h expected=%h", iou, 22'd0);
    end
    sb.delete();
    @(posedge clk); #1;
    release_reset();
  endtask

  // Monitor: zero while in reset, otherwise pop the entry due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_N === 1'b1) begin
        n_cmp++;
        if (iou !== 22'd0) begin
          n_bad++;
          $display("FAIL reset_hold cyc=%0d: iou=%h expected=%h", cyc, iou, 22'd0);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.due != cyc || iou !== e.exp) begin
          n_bad++;
          $display("FAIL result tag=%0d cyc=%0d due=%0d: iou=%h expected=%h",
                   e.tag, cyc, e.due, iou, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    box_t p_k, p_h, id_b, dj_k, dj_h, ka, kb;
    int   lim;
    bit   bad;

    reset_N = 1'b1;
    pos_k = '0; pos_h = '0;
    w_k = '0; h_k = '0; w_h = '0; h_h = '0;

    p_k  = mk(0, 0, 20, 20, 20, 20);
    p_h  = mk(10, 0, 30, 20, 20, 20);
    id_b = mk(0, 0, 2047, 2047, 2047, 2047);
    dj_k = mk(500, 250, 520, 280, 20, 30);
    dj_h = mk(1000, 1200, 1010, 1215, 10, 15);

    repeat (3) @(posedge clk);
    #1;
    release_reset();

    drive(dj_k, dj_h, 22'h000000);
    drive(id_b, id_b, 22'h200000);
    drive(p_k, p_h, 22'h0AAAAA);
    drive(mk(0, 0, 40, 40, 40, 40), mk(10, 10, 20, 20, 10, 10), 22'h020000);
    drive(mk(0, 0, 10, 10, 10, 10), mk(10, 0, 20, 10, 10, 10), 22'h000000);
    drive(mk(0, 0, 10, 10, 10, 10), mk(0, 10, 10, 20, 10, 10), 22'h000000);
    drive(p_k, p_h, 22'h0AAAAA);
    drive(id_b, id_b, 22'h200000);
    drive(dj_k, dj_h, 22'h000000);

    for (int i = 0; i < 150; i++) begin
      lim = ($urandom_range(3, 0) == 0) ? 2047 : 80;
      bad = ($urandom_range(7, 0) == 0);
      ka  = rand_box(lim, bad);
      kb  = rand_box(lim, bad);
      drive(ka, kb, ref_iou(ka, kb));
    end

    // Fill the pipeline with non-zero results, then reset mid-stream.
    drive(p_k, p_h, 22'h0AAAAA);
    drive(id_b, id_b, 22'h200000);
    drive(p_k, p_h, 22'h0AAAAA);
    mid_reset();

    drive(p_k, p_h, 22'h0AAAAA);
    for (int i = 0; i < 150; i++) begin
      lim = ($urandom_range(3, 0) == 0) ? 2047 : 80;
      bad = ($urandom_range(7, 0) == 0);
      ka  = rand_box(lim, bad);
      kb  = rand_box(lim, bad);
      drive(ka, kb, ref_iou(ka, kb));
    end

    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d expected=%0d", sb.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
